// File: rtl/game_pkg.sv
// game_pkg: shared screen constants, run-state encoding and dinosaur geometry defaults
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 400;

    localparam int DEF_DINO_X  = 80;
    localparam int DEF_DINO_W  = 40;
    localparam int DEF_DINO_H  = 43;
    localparam int DEF_JUMP_V  = 14;
    localparam int DEF_GRAVITY = 1;

    typedef enum logic [1:0] {IDLE, RUN, AIR} state_t;

endpackage

// File: rtl/dino_jump_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge pulse
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [2:0] r_sh;

    // Two metastability flops, then a third flop holding the previous synchronised level.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sh <= '0;
        else       r_sh <= {r_sh[1:0], i_async};
    end

    assign o_pulse = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/dino_jump.sv
// dino_jump: game run state, per-frame jump physics and registered dinosaur sprite pixel
module dino_jump
    import game_pkg::*;
#(
    parameter int DINO_X  = DEF_DINO_X,
    parameter int DINO_W  = DEF_DINO_W,
    parameter int DINO_H  = DEF_DINO_H,
    parameter int JUMP_V  = DEF_JUMP_V,
    parameter int GRAVITY = DEF_GRAVITY
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       fresh,
    input  logic       button_jump,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    output logic       game_status,
    output logic       px
);

    logic       w_tick;
    logic       w_btn;
    state_t     r_state;
    state_t     w_state_b;
    state_t     w_state_n;
    logic [7:0] r_h;
    logic [7:0] w_h_n;
    logic [5:0] r_v;
    logic [5:0] w_v_b;
    logic [5:0] w_v_n;
    logic [8:0] w_sum;
    logic       w_btn_run;
    logic       w_land;
    logic       w_step;
    logic [9:0] w_rh;
    logic       w_px_n;

    sync_edge u_sync_fresh (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (fresh),
        .o_pulse (w_tick)
    );

    sync_edge u_sync_btn (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (button_jump),
        .o_pulse (w_btn)
    );

    // State and physics registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_n;
            r_h     <= w_h_n;
            r_v     <= w_v_n;
        end
    end

    // The button acts first; a coincident frame tick then steps the physics in the resulting state.
    always_comb begin
        w_btn_run = r_state == RUN && w_btn;
        w_state_b = (r_state == IDLE && w_btn) ? RUN : w_btn_run ? AIR : r_state;
        w_v_b     = w_btn_run ? 6'(JUMP_V) : r_v;
        w_sum     = {1'b0, r_h} + {{3{w_v_b[5]}}, w_v_b};
        w_land    = w_sum[8] || w_sum == '0;
        w_step    = w_tick && w_state_b == AIR;
        w_state_n = (w_step && w_land) ? RUN : w_state_b;
        w_h_n     = !w_step ? r_h : w_land ? '0 : w_sum[7:0];
        w_v_n     = !w_step ? w_v_b : w_land ? '0 : w_v_b - 6'(GRAVITY);
    end

    // Box test on row+h avoids a signed subtraction when the dinosaur rises.
    always_comb begin
        w_rh   = {1'b0, row_addr} + {2'b0, r_h};
        w_px_n = row_addr < 9'(SCREEN_H) && col_addr < 10'(SCREEN_W)
              && col_addr >= 10'(DINO_X) && col_addr < 10'(DINO_X + DINO_W)
              && w_rh >= 10'(GROUND_Y - DINO_H) && w_rh < 10'(GROUND_Y);
    end

    // Pixel output register, one clock behind the scan address.
    always_ff @(posedge CLK) begin
        if (RESET) px <= 1'b0;
        else       px <= w_px_n;
    end

    assign game_status = r_state != IDLE;

endmodule

// File: tb/tb_dino_jump.sv
// tb_dino_jump: directed stimulus with a queued-expectation scoreboard for dino_jump
module tb_dino_jump;
  import game_pkg::*;
  localparam int K_STATUS = 0;
  localparam int K_PX     = 1;
  localparam int K_H      = 2;
  localparam int K_STATE  = 3;
  typedef struct {
    string name;
    int    kind;
    int    exp;
  } chk_t;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       fresh;
  logic       button_jump;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       game_status;
  logic       px;
  chk_t q[$];
  int   total = 0;
  int   bad   = 0;
  int ck_tick[5] = '{1, 2, 14, 28, 29};
  int ck_h[5]    = '{14, 27, 105, 14, 0};
  dino_jump dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .fresh       (fresh),
    .button_jump (button_jump),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .game_status (game_status),
    .px          (px)
  );
  always #5 CLK = ~CLK;
  initial begin
    #5ms;
    bad++;
    $display("FAIL timeout: stimulus did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  function automatic int actual(input int kind);
    case (kind)
      K_STATUS: return int'(game_status);
      K_PX:     return int'(px);
      K_H:      return int'(dut.r_h);
      default:  return int'(dut.r_state);
    endcase
  endfunction
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      chk_t c;
      int   a;
      c = q.pop_front();
      a = actual(c.kind);
      total++;
      if (a != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", c.name, a, c.exp);
      end
    end
  end
  task automatic expect_val(input string name, input int kind, input int exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    q.push_back(c);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic tick();
    fresh = 1'b1;
    repeat (4) step();
    fresh = 1'b0;
    repeat (4) step();
  endtask
  task automatic press();
    button_jump = 1'b1;
    repeat (4) step();
    button_jump = 1'b0;
    repeat (4) step();
  endtask
  initial begin
    RESET       = 1'b1;
    fresh       = 1'b0;
    button_jump = 1'b0;
    row_addr    = '0;
    col_addr    = '0;
    repeat (3) step();
    total++;
    if (game_status !== 1'b0 || px !== 1'b0) begin
      bad++;
      $display("FAIL reset_direct: game_status=%b px=%b", game_status, px);
    end
    expect_val("reset_status", K_STATUS, 0);
    expect_val("reset_px", K_PX, 0);
    step();
    RESET = 1'b0;
    row_addr = 9'd380; col_addr = 10'd100; step();
    expect_val("px_inside", K_PX, 1);
    step();
    row_addr = 9'd400; step();
    expect_val("px_ground_row", K_PX, 0);
    step();
    row_addr = 9'd357; col_addr = 10'd80; step();
    expect_val("px_top_left", K_PX, 1);
    step();
    row_addr = 9'd356; step();
    expect_val("px_above_top", K_PX, 0);
    step();
    row_addr = 9'd399; col_addr = 10'd119; step();
    expect_val("px_bottom_right", K_PX, 1);
    step();
    col_addr = 10'd120; step();
    expect_val("px_right_edge", K_PX, 0);
    step();
    col_addr = 10'd79; step();
    expect_val("px_left_edge", K_PX, 0);
    step();
    row_addr = 9'd380; col_addr = 10'd100;
    button_jump = 1'b1;
    repeat (4) step();
    expect_val("idle_to_run_status", K_STATUS, 1);
    step();
    repeat (5) tick();
    expect_val("held_btn_h", K_H, 0);
    expect_val("held_btn_state", K_STATE, int'(RUN));
    step();
    repeat (950) step();
    button_jump = 1'b0;
    repeat (4) step();
    for (int pass = 0; pass < 2; pass++) begin
      int ci;
      ci = 0;
      press();
      expect_val(pass == 0 ? "launch_state" : "launch2_state", K_STATE, int'(AIR));
      expect_val(pass == 0 ? "launch_h" : "launch2_h", K_H, 0);
      step();
      for (int t = 1; t <= 29; t++) begin
        tick();
        if (ci < 5 && ck_tick[ci] == t) begin
          expect_val($sformatf("jump%0d_tick%0d_h", pass, t), K_H, ck_h[ci]);
          step();
          ci++;
        end
        if (pass == 1 && t == 5) press();
        if (pass == 0 && t == 14) begin
          row_addr = 9'd252; step();
          expect_val("px_apex_top", K_PX, 1);
          step();
          row_addr = 9'd295; step();
          expect_val("px_apex_below", K_PX, 0);
          step();
          row_addr = 9'd294; step();
          expect_val("px_apex_bottom", K_PX, 1);
          step();
          row_addr = 9'd380;
        end
      end
      expect_val($sformatf("jump%0d_land_state", pass), K_STATE, int'(RUN));
      step();
    end
    press();
    repeat (10) tick();
    expect_val("pre_reset_h", K_H, 95);
    step();
    RESET = 1'b1;
    step();
    expect_val("midjump_reset_h", K_H, 0);
    expect_val("midjump_reset_status", K_STATUS, 0);
    expect_val("midjump_reset_px", K_PX, 0);
    step();
    RESET = 1'b0;
    step();
    expect_val("post_reset_px", K_PX, 1);
    step();
    press();
    expect_val("restart_state", K_STATE, int'(RUN));
    step();
    fresh = 1'b1;
    button_jump = 1'b1;
    repeat (4) step();
    fresh = 1'b0;
    button_jump = 1'b0;
    repeat (4) step();
    expect_val("same_cycle_h", K_H, 14);
    expect_val("same_cycle_state", K_STATE, int'(AIR));
    step();
    tick();
    expect_val("same_cycle_next_h", K_H, 27);
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
